// File: rtl/adc_chan_arbiter_pkg.sv
// Shared definitions for the ADC0809 channel arbiter.
// Provides the FSM state encoding and the channel/data/id field widths.
package adc_chan_arbiter_pkg;

    localparam int CHAN_W = 3;
    localparam int DATA_W = 8;
    localparam int ID_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/adc_chan_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports: req (request vector), ptr (last winner); grant (one-hot),
// grant_idx (winner index), any (at least one request present).
module rr_arbiter
    import adc_chan_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any
);

    int j;

    // Search starts one above the last winner and wraps, so the last
    // winner has the lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/adc_chan_arbiter.sv
// Round-robin arbiter sharing one ADC0809 conversion path among NREQ clients.
// Ports: req_valid/req_chan/req_ready (clients), rsp_* (tagged result),
// conv_chan/conv_start/conv_done/conv_data (ADC driver), busy (not idle).
module adc_chan_arbiter
    import adc_chan_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int SETUP_CYC = 4,
    parameter int TIMEOUT   = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [CHAN_W*NREQ-1:0] req_chan,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic [CHAN_W-1:0]      conv_chan,
    output logic                   conv_start,
    input  logic                   conv_done,
    input  logic [DATA_W-1:0]      conv_data,
    output logic                   busy
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int SET_W = $clog2(SETUP_CYC + 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NREQ-1:0]    req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CHAN_W-1:0]  conv_chan_q, conv_chan_d;
    logic               conv_start_q, conv_start_d;
    logic               busy_q, busy_d;

    logic [NREQ-1:0]    gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        set_cnt_d    = set_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        req_ready_d  = '0;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        conv_chan_d  = conv_chan_q;
        conv_start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready_d = gnt;
                    conv_chan_d = req_chan[CHAN_W*int'(gnt_idx) +: CHAN_W];
                    id_d        = gnt_idx;
                    ptr_d       = gnt_idx;
                    set_cnt_d   = '0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Start is raised on the way out so it is a registered pulse.
                if (set_cnt_q == SET_W'(SETUP_CYC - 1)) begin
                    conv_start_d = 1'b1;
                    state_d      = ST_START;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_START: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Done has priority over an expiring timeout.
                if (conv_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = conv_data;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= ID_W'(NREQ - 1);
            id_q         <= '0;
            set_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            conv_chan_q  <= '0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            set_cnt_q    <= set_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            conv_chan_q  <= conv_chan_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign conv_chan  = conv_chan_q;
    assign conv_start = conv_start_q;
    assign busy       = busy_q;

endmodule
